// File: rtl/exp_engine.sv
// Iterative e^x estimator: truncated Taylor series with one multiply per cycle.
// Each iteration multiplies the running term by x, then by 1/i, and accumulates it.
module exp_engine #(
  parameter int N_TERMS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] x,
  output logic [17:0] result,
  output logic        done,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, INIT, MULX, MULC, DONE} state_t;

  localparam logic [4:0] N_LAST = 5'(N_TERMS);

  state_t      state_reg, state_next;
  logic [17:0] term_reg, sum_reg, result_reg;
  logic [15:0] xreg_reg;
  logic [4:0]  i_reg;

  logic [16:0] recip_rom [0:15];
  logic [33:0] prod_x;
  logic [34:0] prod_c;
  logic [17:0] term_x, term_c, sum_sat;
  logic [18:0] sum_ext;

  // floor(2^16 / i); entry 0 is never addressed
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_recip
      if (gi == 0) begin : g_zero
        assign recip_rom[gi] = 17'd0;
      end else begin : g_val
        assign recip_rom[gi] = 17'(65536 / gi);
      end
    end
  endgenerate

  assign prod_x  = {16'd0, term_reg} * {18'd0, xreg_reg};
  assign term_x  = 18'(prod_x >> 16);
  assign prod_c  = {17'd0, term_reg} * {18'd0, recip_rom[i_reg[3:0]]};
  assign term_c  = 18'(prod_c >> 16);
  assign sum_ext = {1'b0, sum_reg} + {1'b0, term_c};
  assign sum_sat = sum_ext[18] ? 18'h3FFFF : sum_ext[17:0];

  always_comb begin
    state_next = state_reg;
    if (start) begin
      state_next = INIT;
    end else begin
      case (state_reg)
        IDLE:    state_next = IDLE;
        INIT:    state_next = MULX;
        MULX:    state_next = MULC;
        MULC:    state_next = (i_reg < N_LAST) ? MULX : DONE;
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg  <= IDLE;
      term_reg   <= '0;
      sum_reg    <= '0;
      xreg_reg   <= '0;
      i_reg      <= '0;
      result_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        INIT: begin
          xreg_reg <= x;
          term_reg <= 18'h10000;
          sum_reg  <= 18'h10000;
          i_reg    <= 5'd1;
        end
        MULX: term_reg <= term_x;
        MULC: begin
          term_reg <= term_c;
          sum_reg  <= sum_sat;
          i_reg    <= i_reg + 5'd1;
          // an abort via start leaves result untouched
          if (state_next == DONE) result_reg <= sum_sat;
        end
        default: ;
      endcase
    end
  end

  assign result = result_reg;
  assign done   = (state_reg == DONE);
  assign busy   = (state_reg == INIT) || (state_reg == MULX) || (state_reg == MULC);

endmodule

// File: doc/exp_engine.md
EXP_ENGINE -- requirements
Module: exp_engine

Interface
REQ-001 Parameter N_TERMS, default 8, number of Taylor-series iterations after the constant term; legal range 1..15.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
REQ-004 start  input  1  level request from the main controller (EngStart); every cycle it is high (re)launches a computation.
REQ-005 x  input  16  unsigned operand, Q0.16 (value x/65536, range [0,1)).
REQ-006 result  output  18  unsigned e^x estimate, Q2.16, registered.
REQ-007 done  output  1  level; high while the engine holds a valid result (engDone).
REQ-008 busy  output  1  high while a computation is in progress (INIT, MULX, MULC).

Function
REQ-009 The FSM SHALL have five states: IDLE, INIT, MULX, MULC, DONE.
REQ-010 Transitions SHALL be: any state with start=1 -> INIT; IDLE with start=0 -> IDLE; INIT -> MULX; MULX -> MULC; MULC -> MULX if i<N_TERMS, else DONE; DONE with start=0 -> DONE.
REQ-011 start SHALL have priority over every other transition, aborting any computation in progress without updating result.
REQ-012 x SHALL be captured into an internal register only in INIT, i.e. one cycle after the last cycle start is high; x changes at other times SHALL have no effect.
REQ-013 INIT SHALL set term=1.0 (18'h10000), sum=1.0 (18'h10000), iteration index i=1.
REQ-014 MULX SHALL set term = floor(term*xreg / 2^16), with the 34-bit product truncated to 18 bits.
REQ-015 MULC SHALL set term' = floor(term*recip(i) / 2^16), where recip(i)=floor(2^16/i) is a 17-bit constant (recip(1)=2^16); it SHALL set sum = sum + term' and i = i+1.
REQ-016 The sum addition SHALL saturate at 18'h3FFFF.
REQ-017 On the MULC -> DONE transition, result SHALL be loaded with the final sum; result SHALL change at no other time except reset.
REQ-018 done SHALL be 1 exactly in DONE; busy SHALL be 1 exactly in INIT, MULX and MULC; done and busy SHALL never be 1 together.
REQ-019 Latency: with start high only in cycle 0, the FSM SHALL be in INIT in cycle 1 and iteration k SHALL occupy cycles 2k and 2k+1; done SHALL first be high in cycle 2*N_TERMS+2 (cycle 18 for the default).
REQ-020 done SHALL stay high until start or reset; start in DONE SHALL deassert done the following cycle.
REQ-021 Start held high for several cycles SHALL keep the FSM in INIT; computation SHALL begin the cycle after start falls.

Reset
REQ-022 reset=0 at a clock edge SHALL force state=IDLE, result=0, term=0, sum=0, xreg=0, i=0, done=0, busy=0; it SHALL take precedence over start.
REQ-023 Reset asserted mid-computation SHALL abort it; done SHALL not assert until a new start completes.
REQ-024 Asynchronous reset behaviour is forbidden; reset SHALL have no effect between clock edges.

Verification
REQ-025 Reset, then start one cycle with x=0 -> done rises in cycle 18 with result=18'h10000 exactly; busy high in cycles 1..17.
REQ-026 x=16'h8000 (0.5), one-cycle start -> result within 16 LSB of 108051 (e^0.5); done held over 5 idle cycles; result stable.
REQ-027 x=16'hFFFF -> result within 24 LSB of 178142; no saturation; x is changed to 0 in cycle 3 -> result unaffected.
REQ-028 Start held 3 cycles with x changing each cycle -> computation uses the x present in the INIT cycle after start falls; done in cycle 2+18 after the first start edge.
REQ-029 Restart in cycle 7 of a run -> run aborted, result unchanged, done rises 18 cycles after the new start; restart from DONE -> done drops the next cycle.
REQ-030 reset=0 in cycle 9 of a run, together with start=1 -> IDLE, all outputs 0; no done until the next start completes.
